// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-length helpers
// used by the TX block (and a future RX block).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Serial bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

  function automatic int frame_clks(input int clks_per_bit, input int data_w,
                                    input int parity_en, input int stop_bits);
    return clks_per_bit * frame_bits(data_w, parity_en, stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period; a synchronous clear restarts the period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign bit_tick = (cnt == CNT_LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a byte FIFO read port: pops one byte per frame and
// sends start, LSB-first data, optional parity and stop bits on a registered txd.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enb,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_enb,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_t         state, state_next;
  logic [IDX_W-1:0]  bit_idx, bit_idx_next;
  logic [DATA_W-1:0] shreg, data_shift;
  logic [CNT_W-1:0]  cnt;
  logic              bit_tick, state_chg, txd_next, done_next;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_chg),
    .cnt      (cnt),
    .bit_tick (bit_tick)
  );

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    case (state)
      IDLE:   if (tx_enb && !fifo_empty) state_next = POP;
      POP:    state_next = WAIT;
      WAIT:   state_next = START;
      START:  if (bit_tick) state_next = DATA;
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == IDX_DATA_LAST) state_next = (PARITY_EN != 0) ? PARITY : STOP;
          else                          bit_idx_next = bit_idx + 1'b1;
        end
      end
      PARITY: if (bit_tick) state_next = STOP;
      STOP: begin
        if (bit_tick) begin
          if (bit_idx == IDX_STOP_LAST) state_next = (tx_enb && !fifo_empty) ? POP : IDLE;
          else                          bit_idx_next = bit_idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // bit_idx and the baud counter both restart on entry to any state.
    state_chg = (state_next != state);
    if (state_chg) bit_idx_next = '0;
  end

  // txd is registered, so it is computed from where the FSM is heading.
  always_comb begin
    data_shift = shreg >> bit_idx_next;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = data_shift[0];
      PARITY:  txd_next = (^shreg) ^ 1'(PARITY_ODD);
      default: txd_next = 1'b1;
    endcase
    // Registered pulse lands on the final stop cycle, so arm it one cycle early.
    done_next = (state == STOP) && (bit_idx == IDX_STOP_LAST) && (cnt == CNT_PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      txd     <= txd_next;
      tx_done <= done_next;
      if (state == WAIT) shreg <= fifo_data;
    end
  end

  assign fifo_rd_enb = (state == POP);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: an 8N1 instance behind an 8-entry FIFO
// model, plus even-parity/2-stop and odd-parity instances driven directly.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8N1 instance with FIFO model
  logic       tx_enb = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       rd0, txd0, busy0, done0;

  // parity instances share a hand-driven read port
  logic       enb_p = 1'b0, enb_o = 1'b0, aux_empty = 1'b1;
  logic [7:0] aux_data = 8'h00;
  logic       rd_p, txd_p, busy_p, done_p;
  logic       rd_o, txd_o, busy_o, done_o;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_enb(tx_enb), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_enb(rd0), .txd(txd0), .busy(busy0), .tx_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst(rst), .tx_enb(enb_p), .fifo_empty(aux_empty), .fifo_data(aux_data),
    .fifo_rd_enb(rd_p), .txd(txd_p), .busy(busy_p), .tx_done(done_p));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst(rst), .tx_enb(enb_o), .fifo_empty(aux_empty), .fifo_data(aux_data),
    .fifo_rd_enb(rd_o), .txd(txd_o), .busy(busy_o), .tx_done(done_o));

  // 8-entry FIFO model: data_out registered, valid the cycle after the pop
  logic [7:0] mem [8];
  int wr_cnt = 0, rd_cnt = 0, underflow = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rd0) begin
      if (wr_cnt == rd_cnt) underflow <= underflow + 1;
      else begin
        fifo_data <= mem[rd_cnt % 8];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_cnt % 8] = d;
    wr_cnt++;
  endtask

  // selected-instance view for the single-frame checks
  int   sel = 0;
  logic m_txd, m_rd, m_busy, m_done;
  always_comb begin
    case (sel)
      1:       {m_txd, m_rd, m_busy, m_done} = {txd_p, rd_p, busy_p, done_p};
      2:       {m_txd, m_rd, m_busy, m_done} = {txd_o, rd_o, busy_o, done_o};
      default: {m_txd, m_rd, m_busy, m_done} = {txd0, rd0, busy0, done0};
    endcase
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Line decoder on the 8N1 output: samples mid-bit, collects received bytes.
  logic [7:0] rx_q[$];
  logic [7:0] dec_byte;
  int frame_err = 0;
  initial forever begin
    @(negedge clk);
    if (rst && txd0 === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        dec_byte[k] = txd0;
      end
      repeat (CPB) @(negedge clk);
      if (txd0 !== 1'b1) frame_err++;
      rx_q.push_back(dec_byte);
    end
  end

  // Reference line waveform: one entry per clk starting at the start bit.
  function automatic logic [63:0] ref_line(input logic [7:0] d, input int pe, input int po,
                                           input int sb, output int len);
    logic bits[$];
    logic [63:0] v = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe != 0) bits.push_back((^d) ^ 1'(po));
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    len = bits.size() * CPB;
    for (int c = 0; c < len; c++) v[c] = bits[c / CPB];
    return v;
  endfunction

  int cfg_pe[3] = '{0, 1, 1};
  int cfg_po[3] = '{0, 0, 1};
  int cfg_sb[3] = '{1, 2, 1};

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         exp_len;   // cycle of tx_done after WAIT
    int         exp_par;   // expected parity bit, -1 if none
  } vec_t;

  task automatic wait_pop(input string name);
    int t = 0;
    while (!m_rd && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(name, m_rd, 1'b1);
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    logic [63:0] cap = '0, exp;
    int len, done_at = -1, n_done = 0, extra_rd = 0;
    string p = $sformatf("vec%0d_", idx);
    sel = v.sel;
    case (v.sel)
      0:       begin push(v.data); tx_enb = 1'b1; end
      1:       begin aux_data = v.data; aux_empty = 1'b0; enb_p = 1'b1; end
      default: begin aux_data = v.data; aux_empty = 1'b0; enb_o = 1'b1; end
    endcase
    wait_pop({p, "pop"});
    tx_enb = 1'b0; enb_p = 1'b0; enb_o = 1'b0; aux_empty = 1'b1;
    @(negedge clk);
    check({p, "wait_txd"}, m_txd, 1'b1);
    exp = ref_line(v.data, cfg_pe[v.sel], cfg_po[v.sel], cfg_sb[v.sel], len);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      cap[c-1] = m_txd;
      if (m_done) begin n_done++; done_at = c; end
      if (m_rd) extra_rd++;
    end
    @(negedge clk);
    check({p, "line"}, cap, exp);
    check({p, "done_cycle"}, done_at, v.exp_len);
    check({p, "done_pulses"}, n_done, 1);
    check({p, "extra_pop"}, extra_rd, 0);
    if (v.exp_par >= 0) check({p, "parity_bit"}, cap[38], v.exp_par);
    check({p, "busy_after"}, m_busy, 1'b0);
  endtask

  task automatic test_empty_idle();
    int n_rd = 0, n_txd = 0, n_busy = 0;
    sel = 0;
    tx_enb = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd0) n_rd++;
      if (txd0 !== 1'b1) n_txd++;
      if (busy0) n_busy++;
    end
    tx_enb = 1'b0;
    check("empty_rd", n_rd, 0);
    check("empty_txd", n_txd, 0);
    check("empty_busy", n_busy, 0);
  endtask

  task automatic test_back_to_back();
    localparam int N = 1 + 42 * 8 + 4;
    logic exp_txd[N], exp_rd[N], exp_done[N];
    logic [63:0] fl;
    int flen, e_txd = 0, e_rd = 0, e_done = 0, base = rd_cnt, u0 = underflow;
    for (int i = 0; i < N; i++) begin exp_txd[i] = 1'b1; exp_rd[i] = 1'b0; exp_done[i] = 1'b0; end
    for (int k = 0; k < 8; k++) begin
      int s = 1 + 42 * k;
      fl = ref_line(8'(k), 0, 0, 1, flen);
      for (int j = 0; j < 40; j++) exp_txd[s+j] = fl[j];
      exp_done[s+39] = 1'b1;
      if (k < 7) exp_rd[s+40] = 1'b1;
    end
    rx_q.delete();
    sel = 0;
    for (int k = 0; k < 8; k++) push(8'(k));
    tx_enb = 1'b1;
    wait_pop("b2b_first_pop");
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (txd0 !== exp_txd[i]) e_txd++;
      if (rd0 !== exp_rd[i]) e_rd++;
      if (done0 !== exp_done[i]) e_done++;
    end
    tx_enb = 1'b0;
    check("b2b_txd_err", e_txd, 0);
    check("b2b_rd_err", e_rd, 0);
    check("b2b_done_err", e_done, 0);
    check("b2b_pops", rd_cnt - base, 8);
    check("b2b_empty", fifo_empty, 1'b1);
    check("b2b_underflow", underflow - u0, 0);
    check("b2b_rx_count", rx_q.size(), 8);
    for (int k = 0; k < 8 && k < rx_q.size(); k++) check($sformatf("b2b_rx%0d", k), rx_q[k], k);
  endtask

  task automatic drain(input string name);
    int t = 0;
    tx_enb = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!(fifo_empty && !busy0) && t < 3000);
    check(name, t < 3000, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enb_drop();
    int base = rd_cnt, n_rd = 0, n_txd = 0;
    logic [7:0] exp_b[3] = '{8'hA1, 8'hB2, 8'hC3};
    rx_q.delete();
    sel = 0;
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    tx_enb = 1'b1;
    wait_pop("drop_pop");
    repeat (12) @(negedge clk);
    check("drop_in_data", busy0, 1'b1);
    tx_enb = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd0) n_rd++;
      if (txd0 !== 1'b1) n_txd++;
    end
    check("drop_pops", rd_cnt - base, 1);
    check("drop_fifo_count", wr_cnt - rd_cnt, 2);
    check("drop_idle_rd", n_rd, 0);
    check("drop_idle_txd", n_txd, 0);
    check("drop_busy", busy0, 1'b0);
    drain("drop_drain_timeout");
    tx_enb = 1'b0;
    check("drop_total_pops", rd_cnt - base, 3);
    check("drop_rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++) check($sformatf("drop_rx%0d", i), rx_q[i], exp_b[i]);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int base = rd_cnt, u0 = underflow, f0 = frame_err, n_err = 0;
    rx_q.delete();
    sel = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom % 8 == 0 && (wr_cnt - rd_cnt) < 8 && exp_q.size() < 20) begin
        b = 8'($urandom);
        push(b);
        exp_q.push_back(b);
      end
      if ($urandom % 40 == 0) tx_enb = ~tx_enb;
    end
    drain("rand_drain_timeout");
    tx_enb = 1'b0;
    check("rand_rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) n_err++;
    check("rand_data_err", n_err, 0);
    check("rand_pops", rd_cnt - base, exp_q.size());
    check("rand_underflow", underflow - u0, 0);
    check("rand_frame_err", frame_err - f0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int n_rd = 0;
    sel = 0;
    push(8'h00);
    tx_enb = 1'b1;
    wait_pop("rst_pop");
    tx_enb = 1'b0;
    push(8'h5A);
    repeat (11) @(negedge clk);
    check("rst_pre_txd", txd0, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_txd", txd0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_rd", rd0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_fifo_count", wr_cnt - rd_cnt, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd0) n_rd++;
    end
    check("rst_hold_rd", n_rd, 0);
    rst = 1'b1;
    rx_q.delete();
    drain("rst_drain_timeout");
    tx_enb = 1'b0;
    check("rst_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rst_rx_byte", rx_q[0], 8'h5A);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 8'hA5, 40, -1};
    vecs[1] = '{0, 8'h00, 40, -1};
    vecs[2] = '{0, 8'hFF, 40, -1};
    vecs[3] = '{0, 8'h01, 40, -1};
    vecs[4] = '{0, 8'h80, 40, -1};
    vecs[5] = '{1, 8'h07, 48,  1};
    vecs[6] = '{2, 8'h07, 44,  0};
    vecs[7] = '{1, 8'hA5, 48,  0};
    vecs[8] = '{2, 8'hA5, 44,  1};

    #3 rst = 1'b0;
    #1;
    check("reset_txd", txd0, 1'b1);
    check("reset_busy", busy0, 1'b0);
    check("reset_rd", rd0, 1'b0);
    check("reset_done", done0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);
    test_empty_idle();
    test_back_to_back();
    test_enb_drop();
    test_random();
    test_reset_mid_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
